// File: rtl/pkt_buf_pkg.sv
// Shared definitions for the packet copy buffer (writer and reader side).
// Contents: buffer geometry constants, derived address/length widths,
// the published descriptor layout and the ingress writer state encoding.
package pkt_buf_pkg;

  localparam int PKT_DEPTH   = 3072;
  localparam int PKT_MAX_LEN = 1536;
  localparam int PKT_MIN_LEN = 60;

  localparam int PKT_AW = $clog2(PKT_DEPTH);
  localparam int PKT_LW = $clog2(PKT_MAX_LEN + 1);

  typedef struct packed {
    logic [PKT_AW-1:0] addr;
    logic [PKT_LW-1:0] len;
  } pkt_desc_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } pkt_state_e;

endpackage

// File: rtl/ring_ptr_inc.sv
// Ring pointer helper for a buffer of arbitrary (non power of two) depth.
// Ports:
//   ia      : address about to be written
//   ird_ptr : reader release pointer (oldest address still in use)
//   onext   : ia advanced by one, wrapping pDEPTH-1 -> 0
//   ospace  : 1 when a word may be written at ia, i.e. next(ia) != ird_ptr,
//             which keeps one slot free so full and empty stay distinct
module ring_ptr_inc #(
  parameter int pDEPTH = 3072
) (
  input  logic [$clog2(pDEPTH)-1:0] ia,
  input  logic [$clog2(pDEPTH)-1:0] ird_ptr,
  output logic [$clog2(pDEPTH)-1:0] onext,
  output logic                      ospace
);

  localparam int AW = $clog2(pDEPTH);

  assign onext  = (ia == AW'(pDEPTH - 1)) ? '0 : ia + 1'b1;
  assign ospace = (onext != ird_ptr);

endmodule

// File: rtl/pkt_wr_ctrl.sv
// Ingress write controller for the packet copy buffer. Writes each accepted
// byte of a sop/eop framed stream into the ring buffer, commits good packets
// by advancing wr_ptr and publishing a {start, len} descriptor, and rewinds
// runts, oversize, errored, aborted and non-fitting packets.
// Ports:
//   iclk, irst        : clock, asynchronous active-high reset
//   idata/ivalid/isop/ieop/ierr : ingress stream, no backpressure
//   ird_ptr           : reader release pointer
//   owr_en/ow_addr/ow_data : registered buffer write port
//   odesc_valid/odesc_addr/odesc_len, idesc_rdy : one-entry descriptor handshake
//   odrop_cnt         : saturating dropped-packet counter
module pkt_wr_ctrl
  import pkt_buf_pkg::*;
#(
  parameter int pBITS    = 8,
  parameter int pDEPTH   = PKT_DEPTH,
  parameter int pMAX_LEN = PKT_MAX_LEN,
  parameter int pMIN_LEN = PKT_MIN_LEN
) (
  input  logic                           iclk,
  input  logic                           irst,
  input  logic [pBITS-1:0]               idata,
  input  logic                           ivalid,
  input  logic                           isop,
  input  logic                           ieop,
  input  logic                           ierr,
  input  logic [$clog2(pDEPTH)-1:0]      ird_ptr,
  output logic                           owr_en,
  output logic [$clog2(pDEPTH)-1:0]      ow_addr,
  output logic [pBITS-1:0]               ow_data,
  output logic                           odesc_valid,
  output logic [$clog2(pDEPTH)-1:0]      odesc_addr,
  output logic [$clog2(pMAX_LEN+1)-1:0]  odesc_len,
  input  logic                           idesc_rdy,
  output logic [15:0]                    odrop_cnt
);

  localparam int AW = $clog2(pDEPTH);
  localparam int LW = $clog2(pMAX_LEN + 1);

  pkt_state_e       state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    cur_q, cur_d;
  logic [AW-1:0]    start_q, start_d;
  logic [LW-1:0]    len_q, len_d;
  pkt_desc_t        desc_q, desc_d;
  logic             desc_pend_q, desc_pend_d;
  logic             desc_valid_q, desc_valid_d;
  logic             wr_en_q, wr_en_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic [pBITS-1:0] wr_data_q, wr_data_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;

  logic [AW-1:0] wr_next, cur_next, cur_next2;
  logic          sop_space, cur_space, nxt_space, recv_space, slot_busy;
  logic          do_sop, do_eop;
  logic [LW-1:0] eop_len;
  logic [AW-1:0] eop_next;
  logic [1:0]    n_drop;
  logic [16:0]   drop_sum;

  // Space for a sop byte written at wr_ptr.
  ring_ptr_inc #(.pDEPTH(pDEPTH)) u_inc_wr (
    .ia(wr_ptr_q), .ird_ptr(ird_ptr), .onext(wr_next), .ospace(sop_space));
  // Continuation bytes land at next(cur); the second stage checks that slot.
  ring_ptr_inc #(.pDEPTH(pDEPTH)) u_inc_cur (
    .ia(cur_q), .ird_ptr(ird_ptr), .onext(cur_next), .ospace(cur_space));
  ring_ptr_inc #(.pDEPTH(pDEPTH)) u_inc_nxt (
    .ia(cur_next), .ird_ptr(ird_ptr), .onext(cur_next2), .ospace(nxt_space));

  // cur_space is normally implied; it also halts writing should the reader
  // pointer ever land directly ahead of the last written word.
  assign recv_space = cur_space & nxt_space;

  // The descriptor slot counts as occupied while a commit is still waiting
  // for its last write to land (pend) or an unaccepted descriptor is shown.
  assign slot_busy = desc_pend_q | (desc_valid_q & ~idesc_rdy);

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    cur_d        = cur_q;
    start_d      = start_q;
    len_d        = len_q;
    desc_d       = desc_q;
    desc_pend_d  = 1'b0;
    desc_valid_d = desc_pend_q | (desc_valid_q & ~idesc_rdy);
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    n_drop       = 2'd0;
    do_sop       = 1'b0;
    do_eop       = 1'b0;
    eop_len      = '0;
    eop_next     = '0;

    if (ivalid) begin
      case (state_q)
        RECV: begin
          if (isop) begin
            // Abort: rewind, then treat this beat as a fresh sop.
            n_drop = 2'd1;
            cur_d  = wr_ptr_q;
            do_sop = 1'b1;
          end else if (!recv_space || len_q == LW'(pMAX_LEN)) begin
            n_drop  = 2'd1;
            cur_d   = wr_ptr_q;
            state_d = ieop ? IDLE : DROP;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = cur_next;
            wr_data_d = idata;
            cur_d     = cur_next;
            len_d     = len_q + 1'b1;
            if (ieop) begin
              do_eop   = 1'b1;
              eop_len  = len_q + 1'b1;
              eop_next = cur_next2;
            end
          end
        end
        default: begin
          if (isop) begin
            do_sop = 1'b1;
          end else if (ieop) begin
            state_d = IDLE;
          end
        end
      endcase
    end

    if (do_sop) begin
      start_d = wr_ptr_q;
      cur_d   = wr_ptr_q;
      if (sop_space) begin
        wr_en_d   = 1'b1;
        wr_addr_d = wr_ptr_q;
        wr_data_d = idata;
        len_d     = LW'(1);
        state_d   = RECV;
        if (ieop) begin
          do_eop   = 1'b1;
          eop_len  = LW'(1);
          eop_next = wr_next;
        end
      end else begin
        n_drop  = n_drop + 2'd1;
        state_d = ieop ? IDLE : DROP;
      end
    end

    if (do_eop) begin
      state_d = IDLE;
      if (ierr || (eop_len < LW'(pMIN_LEN)) || slot_busy) begin
        cur_d  = wr_ptr_q;
        n_drop = n_drop + 2'd1;
      end else begin
        wr_ptr_d    = eop_next;
        cur_d       = eop_next;
        desc_d.addr = start_d;
        desc_d.len  = eop_len;
        desc_pend_d = 1'b1;
      end
    end

    drop_sum   = {1'b0, drop_cnt_q} + 17'(n_drop);
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      cur_q        <= '0;
      start_q      <= '0;
      len_q        <= '0;
      desc_q       <= '0;
      desc_pend_q  <= 1'b0;
      desc_valid_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      cur_q        <= cur_d;
      start_q      <= start_d;
      len_q        <= len_d;
      desc_q       <= desc_d;
      desc_pend_q  <= desc_pend_d;
      desc_valid_q <= desc_valid_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign owr_en      = wr_en_q;
  assign ow_addr     = wr_addr_q;
  assign ow_data     = wr_data_q;
  assign odesc_valid = desc_valid_q;
  assign odesc_addr  = desc_q.addr;
  assign odesc_len   = desc_q.len;
  assign odrop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_pkt_wr_ctrl.sv
// Directed bench for pkt_wr_ctrl: fixed packet sequences with hand-computed
// write addresses, descriptors and drop counts.
module tb_pkt_wr_ctrl;

  logic        clk = 1'b0;
  logic        irst;
  logic [7:0]  idata;
  logic        ivalid, isop, ieop, ierr;
  logic [11:0] ird_ptr;
  logic        owr_en;
  logic [11:0] ow_addr;
  logic [7:0]  ow_data;
  logic        odesc_valid;
  logic [11:0] odesc_addr;
  logic [10:0] odesc_len;
  logic        idesc_rdy;
  logic [15:0] odrop_cnt;

  int n_vec = 0;
  int n_bad = 0;

  // Shadow of buffer writes and descriptor handshakes.
  logic [7:0]  mem [0:3071];
  logic [11:0] wa_log [0:8191];
  int          n_wr = 0;
  int          n_acc = 0;

  pkt_wr_ctrl dut (
    .iclk(clk), .irst(irst), .idata(idata), .ivalid(ivalid), .isop(isop),
    .ieop(ieop), .ierr(ierr), .ird_ptr(ird_ptr), .owr_en(owr_en),
    .ow_addr(ow_addr), .ow_data(ow_data), .odesc_valid(odesc_valid),
    .odesc_addr(odesc_addr), .odesc_len(odesc_len), .idesc_rdy(idesc_rdy),
    .odrop_cnt(odrop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (owr_en) begin
      mem[ow_addr]        <= ow_data;
      wa_log[n_wr[12:0]]  <= ow_addr;
      n_wr                <= n_wr + 1;
    end
    if (odesc_valid && idesc_rdy) n_acc <= n_acc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic send_pkt(input int len, input logic [7:0] b0, input logic err, input logic with_eop);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      ivalid = 1'b1;
      isop   = (i == 0);
      ieop   = with_eop && (i == len - 1);
      ierr   = err && (i == len - 1);
      idata  = b0 + 8'(i);
    end
  endtask

  task automatic quiet(input int n);
    repeat (n) begin
      @(negedge clk);
      ivalid = 1'b0; isop = 1'b0; ieop = 1'b0; ierr = 1'b0;
    end
  endtask

  task automatic wait_desc(input string tag, output logic [11:0] a, output logic [10:0] l);
    logic ok;
    ok = 1'b0; a = '0; l = '0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ivalid = 1'b0; isop = 1'b0; ieop = 1'b0; ierr = 1'b0;
      if (odesc_valid) begin
        ok = 1'b1; a = odesc_addr; l = odesc_len;
      end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic check_data(input string tag, input int base, input int len, input logic [7:0] b0);
    int bad;
    logic [7:0] e;
    bad = 0;
    for (int i = 0; i < len; i++) begin
      e = b0 + 8'(i);
      if (mem[(base + i) % 3072] !== e) bad++;
    end
    chk(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no completion, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int s, a0;
    logic [11:0] da;
    logic [10:0] dl;

    irst = 1'b1; ivalid = 1'b0; isop = 1'b0; ieop = 1'b0; ierr = 1'b0;
    idata = '0; ird_ptr = '0; idesc_rdy = 1'b0;
    repeat (3) @(negedge clk);
    irst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_wr_en", 32'(owr_en), 0);
    chk("rst_wr_addr", 32'(ow_addr), 0);
    chk("rst_desc_valid", 32'(odesc_valid), 0);
    chk("rst_desc_addr", 32'(odesc_addr), 0);
    chk("rst_desc_len", 32'(odesc_len), 0);
    chk("rst_drop_cnt", 32'(odrop_cnt), 0);

    // 64-byte packet, descriptor latency and hold with idesc_rdy=0
    s = n_wr;
    send_pkt(64, 8'h00, 1'b0, 1'b1);
    quiet(1);
    chk("p1_last_we", 32'(owr_en), 1);
    chk("p1_last_addr", 32'(ow_addr), 63);
    chk("p1_last_data", 32'(ow_data), 32'h3F);
    chk("p1_desc_not_early", 32'(odesc_valid), 0);
    quiet(1);
    chk("p1_desc_valid", 32'(odesc_valid), 1);
    chk("p1_desc_addr", 32'(odesc_addr), 0);
    chk("p1_desc_len", 32'(odesc_len), 64);
    quiet(3);
    chk("p1_desc_hold", 32'(odesc_valid), 1);
    chk("p1_desc_hold_len", 32'(odesc_len), 64);
    chk("p1_nwr", 32'(n_wr - s), 64);
    chk("p1_first_addr", 32'(wa_log[s[12:0]]), 0);
    check_data("p1_data", 0, 64, 8'h00);
    @(negedge clk); idesc_rdy = 1'b1;
    quiet(1);
    chk("p1_desc_taken", 32'(odesc_valid), 0);

    // Runt then errored packet: both rewound
    a0 = n_acc;
    send_pkt(40, 8'h10, 1'b0, 1'b1);
    quiet(2);
    send_pkt(100, 8'h20, 1'b1, 1'b1);
    quiet(5);
    chk("p2_drop_cnt", 32'(odrop_cnt), 2);
    chk("p2_no_desc", 32'(n_acc - a0), 0);
    s = n_wr;
    send_pkt(64, 8'h40, 1'b0, 1'b1);
    wait_desc("p2_good_desc_seen", da, dl);
    chk("p2_good_addr", 32'(da), 64);
    chk("p2_good_len", 32'(dl), 64);
    chk("p2_good_first", 32'(wa_log[s[12:0]]), 64);
    check_data("p2_good_data", 64, 64, 8'h40);
    quiet(2);

    // Abort mid-packet by a new sop
    send_pkt(30, 8'h80, 1'b0, 1'b0);
    send_pkt(64, 8'hC0, 1'b0, 1'b1);
    wait_desc("p3_desc_seen", da, dl);
    chk("p3_drop_cnt", 32'(odrop_cnt), 3);
    chk("p3_addr", 32'(da), 128);
    chk("p3_len", 32'(dl), 64);
    check_data("p3_data", 128, 64, 8'hC0);
    quiet(2);

    // Descriptor backpressure: second packet dropped, first held
    idesc_rdy = 1'b0;
    send_pkt(64, 8'h11, 1'b0, 1'b1);
    quiet(2);
    send_pkt(64, 8'h22, 1'b0, 1'b1);
    quiet(4);
    chk("p4_valid", 32'(odesc_valid), 1);
    chk("p4_addr_held", 32'(odesc_addr), 192);
    chk("p4_len_held", 32'(odesc_len), 64);
    chk("p4_drop_cnt", 32'(odrop_cnt), 4);
    idesc_rdy = 1'b1;
    quiet(2);

    // Fill up to wr_ptr=3040
    send_pkt(1392, 8'h00, 1'b0, 1'b1);
    wait_desc("fill1_desc_seen", da, dl);
    chk("fill1_addr", 32'(da), 256);
    chk("fill1_len", 32'(dl), 1392);
    send_pkt(1392, 8'h00, 1'b0, 1'b1);
    wait_desc("fill2_desc_seen", da, dl);
    chk("fill2_addr", 32'(da), 1648);

    // Wrap across the end of the ring
    ird_ptr = 12'd3000;
    s = n_wr;
    send_pkt(64, 8'h55, 1'b0, 1'b1);
    wait_desc("wrap_desc_seen", da, dl);
    chk("wrap_addr", 32'(da), 3040);
    chk("wrap_len", 32'(dl), 64);
    chk("wrap_wa_first", 32'(wa_log[s[12:0]]), 3040);
    chk("wrap_wa_32", 32'(wa_log[13'(s + 32)]), 0);
    chk("wrap_wa_last", 32'(wa_log[13'(s + 63)]), 31);
    check_data("wrap_data", 3040, 64, 8'h55);
    send_pkt(64, 8'h66, 1'b0, 1'b1);
    wait_desc("wrap_next_seen", da, dl);
    chk("wrap_next_addr", 32'(da), 32);

    // Asynchronous reset mid-packet
    send_pkt(20, 8'h01, 1'b0, 1'b0);
    #2 irst = 1'b1;
    #1;
    chk("arst_wr_en", 32'(owr_en), 0);
    chk("arst_wr_addr", 32'(ow_addr), 0);
    chk("arst_wr_data", 32'(ow_data), 0);
    chk("arst_desc_addr", 32'(odesc_addr), 0);
    chk("arst_desc_len", 32'(odesc_len), 0);
    chk("arst_drop_cnt", 32'(odrop_cnt), 0);
    ivalid = 1'b0; isop = 1'b0; ieop = 1'b0;
    ird_ptr = 12'd100;
    @(negedge clk);
    @(negedge clk); irst = 1'b0;
    @(negedge clk);

    // Full: 200-byte packet with 99 free words
    a0 = n_acc;
    s = n_wr;
    send_pkt(200, 8'h00, 1'b0, 1'b1);
    quiet(3);
    chk("full_nwr", 32'(n_wr - s), 99);
    chk("full_first", 32'(wa_log[s[12:0]]), 0);
    chk("full_last", 32'(wa_log[13'(s + 98)]), 98);
    chk("full_drop_cnt", 32'(odrop_cnt), 1);
    chk("full_no_desc", 32'(n_acc - a0), 0);
    send_pkt(64, 8'h77, 1'b0, 1'b1);
    wait_desc("full_next_seen", da, dl);
    chk("full_next_addr", 32'(da), 0);
    chk("full_next_len", 32'(dl), 64);
    quiet(2);

    // Abort plus no-space on the new sop: two drops in one cycle
    send_pkt(10, 8'h99, 1'b0, 1'b0);
    ird_ptr = 12'd65;
    send_pkt(1, 8'hAA, 1'b0, 1'b1);
    quiet(3);
    chk("dbl_drop_cnt", 32'(odrop_cnt), 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pkt_wr_ctrl.md
Name: pkt_wr_ctrl

Overview:
Ingress write controller for the packet copy buffer. It accepts a byte stream framed with sop/eop, writes each accepted byte into the dual-port register-file buffer, and manages that buffer as a ring. Good packets are committed and published as a (start address, length) descriptor to the downstream reader. Runts, oversize packets, errored packets and packets that do not fit are rewound and counted.

Parameters:
pBITS, 8, data width (matches the buffer word width)
pDEPTH, 3072, buffer depth in words; not necessarily a power of two
pMAX_LEN, 1536, maximum accepted packet length in words
pMIN_LEN, 60, minimum accepted packet length in words

Ports:
iclk  in  1  clock
irst  in  1  reset, asynchronous, active-high
idata  in  pBITS  stream data
ivalid  in  1  beat valid; no backpressure, a beat is present whenever ivalid=1
isop  in  1  first beat of packet (qualified by ivalid)
ieop  in  1  last beat of packet (qualified by ivalid)
ierr  in  1  packet error flag (sampled on the eop beat)
ird_ptr  in  $clog2(pDEPTH)  reader release pointer: oldest address still in use
owr_en  out  1  buffer write enable
ow_addr  out  $clog2(pDEPTH)  buffer write address
ow_data  out  pBITS  buffer write data
odesc_valid  out  1  descriptor available
odesc_addr  out  $clog2(pDEPTH)  packet start address
odesc_len  out  $clog2(pMAX_LEN+1)  packet length in words
idesc_rdy  in  1  descriptor accepted when odesc_valid&idesc_rdy
odrop_cnt  out  16  dropped-packet count, saturates at 16'hFFFF

Behaviour:
- Reset (asynchronous, any state): state=IDLE, wr_ptr=cur=0, len=0. All outputs are 0.
- Ring pointers:
  - next(a) = (a==pDEPTH-1) ? 0 : a+1.
  - A word may be written only if next(cur) != ird_ptr, so usable capacity is pDEPTH-1.
  - wr_ptr==ird_ptr means the buffer is empty.
- Write path is registered: a beat accepted in cycle T drives owr_en/ow_addr/ow_data during T+1.
- IDLE:
  - ivalid&isop: start=wr_ptr, write the byte at cur=wr_ptr, len=1, go to RECV.
  - If the beat also carries ieop, evaluate commit immediately (see eop rules).
  - If no space, go to DROP without writing; if ieop is also set, count the drop and stay in IDLE.
  - ivalid without isop is ignored.
- RECV, ivalid beat:
  - isop: abort the current packet. Count a drop, rewind cur=wr_ptr, then process the beat as an IDLE sop.
  - No space, or len==pMAX_LEN: no write, rewind cur=wr_ptr, count a drop, go to DROP (IDLE if ieop).
  - Otherwise: write at next(cur), cur=next(cur), len=len+1.
- eop rules, applied on the eop beat after its byte is written:
  - Drop if any of: ierr=1, final len<pMIN_LEN, or odesc_valid still high and not being accepted this cycle. Drop means rewind cur=wr_ptr, count a drop, go to IDLE.
  - Otherwise commit: wr_ptr=next(cur), load descriptor {start, len}, go to IDLE.
- DROP: ignore beats until ieop, then go to IDLE. An isop beat in DROP is handled as in IDLE.
- Descriptor timing:
  - eop beat at cycle T gives last write at T+1 and odesc_valid=1 from T+2. The reader never sees the descriptor before the last word is in memory.
  - odesc_valid holds, with stable data, until idesc_rdy.
  - A one-entry descriptor register only; no queue.
- Rewound bytes may already have been written; they are never published.
- odrop_cnt increments by exactly 1 per dropped packet. If two drop events fall in one cycle (abort plus no-space on the new sop), it increments by 2, still saturating.

Decomposition:
- Shared package pkt_buf_pkg:
  - constants PKT_DEPTH=3072, PKT_MAX_LEN=1536, PKT_MIN_LEN=60
  - derived address/length widths
  - descriptor struct {addr, len}
  - state enum {IDLE, RECV, DROP}
- One natural sub-module: ring_ptr_inc. It computes next(a) and the space check for non-power-of-two depth, and is reusable by the reader side.

Test Plan:
- After reset, a 64-byte packet with bytes 0x00..0x3F: owr_en writes addr 0..63 with matching data; odesc_valid two cycles after eop with addr=0, len=64; with idesc_rdy=1, wr_ptr=64.
- Wrap: drive wr_ptr to 3040 with prior packets and set ird_ptr=3000, then send 64 bytes. Writes go to 3040..3071 then 0..31; descriptor addr=3040, len=64; wr_ptr=32.
- Runt of 40 bytes, then an ierr packet of 100 bytes: no descriptors; odrop_cnt=2; wr_ptr unchanged; the next good packet starts at the old wr_ptr.
- Full: wr_ptr=0, ird_ptr=100, send a 200-byte packet. Writes stop at addr 98; packet dropped; odrop_cnt=1; state returns to IDLE on eop.
- Descriptor backpressure: idesc_rdy=0, two 64-byte packets. The first descriptor is held stable; the second is dropped (odrop_cnt=1); wr_ptr=64.
- Abort and reset: isop mid-packet gives a drop count and the new packet starts at wr_ptr. Asserting irst mid-packet clears all outputs immediately; the next packet is written from addr 0.
